// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port unified memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Width of the wait counter; WAIT_CYCLES must fit in it (0..15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response handshake bundle between the two requesters and the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_write, req1_write;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata
  );

  // Requester side
  modport master (
    output req0_valid, req1_valid, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select: combinational winner pick between the two request ports.
// Policy on contention depends on MEM_ARB_ROUND_ROBIN_EN (alternate vs port 0 priority).
module mem_arb_select
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] reqValid,
  input  logic       lastOwner,
  output logic       grant,
  output logic       anyValid
);

  logic contention;

  assign anyValid   = |reqValid;
  assign contention = &reqValid;

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the input referenced.
  logic unusedLastOwner;
  assign unusedLastOwner = lastOwner;
`endif

  // Single requester wins outright; contention resolved by policy.
  always_comb begin
    grant = PORT_CPU;
    if (contention) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = ~lastOwner;
`else
      grant = PORT_CPU;
`endif
    end else if (reqValid[PORT_LDR]) begin
      grant = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the unified memory for the CPU port (0) and the
// loader/debug port (1). IDLE accepts one request, ACCESS holds the memory for
// WAIT_CYCLES+1 cycles, RESP pulses completion to the owner.
// Optional macro: MEM_ARB_ROUND_ROBIN_EN (alternating arbitration on contention).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_CYCLES[WAIT_W-1:0];

  arbState_t         state, stateNxt;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ, rdataQ;
  logic              writeQ, ownerQ, lastOwner;
  logic [1:0]        reqValid;
  logic              grant, anyValid;

  assign reqValid = {bus.req1_valid, bus.req0_valid};

  mem_arb_select uSel (
    .reqValid (reqValid),
    .lastOwner(lastOwner),
    .grant    (grant),
    .anyValid (anyValid)
  );

  assign mem_addr      = addrQ;
  assign mem_wdata     = wdataQ;
  assign bus.rsp_rdata = rdataQ;

  // State register; async reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next state and all state-decoded outputs; ready only ever asserted in IDLE.
  always_comb begin
    stateNxt       = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    busy           = 1'b1;
    owner          = ownerQ;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        owner = PORT_CPU;
        if (anyValid) begin
          stateNxt       = ACCESS;
          bus.req0_ready = (grant == PORT_CPU);
          bus.req1_ready = (grant == PORT_LDR);
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = writeQ;
        if (cnt == '0) stateNxt = RESP;
      end
      RESP: begin
        bus.rsp0_valid = (ownerQ == PORT_CPU);
        bus.rsp1_valid = (ownerQ == PORT_LDR);
        stateNxt       = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Request latches, wait counter, read capture and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addrQ     <= '0;
      wdataQ    <= '0;
      writeQ    <= 1'b0;
      ownerQ    <= 1'b0;
      rdataQ    <= '0;
      lastOwner <= PORT_LDR;
    end else begin
      unique case (state)
        IDLE: if (anyValid) begin
          cnt    <= WAIT_LD;
          ownerQ <= grant;
          addrQ  <= grant ? bus.req1_addr  : bus.req0_addr;
          wdataQ <= grant ? bus.req1_wdata : bus.req0_wdata;
          writeQ <= grant ? bus.req1_write : bus.req0_write;
        end
        ACCESS: begin
          // Counter is reloaded only in IDLE, so stopping at zero avoids underflow.
          if (cnt == '0) begin
            if (!writeQ) rdataQ <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    lastOwner <= ownerQ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single-port transactions
// plus hand sequences for contention, late requests, mid-access reset and WAIT_CYCLES=0.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, memRdata;
  logic        memEnZ, memWeZ, busyZ, ownerZ;
  logic [31:0] memAddrZ, memWdataZ, memRdataZ;

  int nChecks = 0;
  int nFails  = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busZ ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(memRdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dutZ (
    .clk(clk), .rst_n(rst_n), .bus(busZ),
    .mem_en(memEnZ), .mem_we(memWeZ), .mem_addr(memAddrZ), .mem_wdata(memWdataZ),
    .mem_rdata(memRdataZ), .busy(busyZ), .owner(ownerZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req0_valid = v[0]; bus.req1_valid = v[1];
    bus.req0_write = w;    bus.req1_write = w;
    bus.req0_addr  = a;    bus.req1_addr  = a;
    bus.req0_wdata = d;    bus.req1_wdata = d;
  endtask

  function automatic logic [1:0] rdy();
    return {bus.req1_ready, bus.req0_ready};
  endfunction

  function automatic logic [1:0] rsp();
    return {bus.rsp1_valid, bus.rsp0_valid};
  endfunction

  // One complete transaction on the WAIT_CYCLES=2 instance, checked cycle by cycle.
  task automatic runTxn(input vec_t v);
    logic [1:0] onehot;
    onehot = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(onehot, v.write, v.addr, v.wdata);
    memRdata = v.memData;
    #1;
    chk("accept ready", rdy(), onehot);
    chk("accept busy", busy, 1'b0);
    chk("accept mem_en", mem_en, 1'b0);
    @(negedge clk);
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("access mem_en", mem_en, 1'b1);
      chk("access mem_we", mem_we, v.write);
      chk("access mem_addr", mem_addr, v.addr);
      if (v.write) chk("access mem_wdata", mem_wdata, v.wdata);
      chk("access owner", owner, v.port);
      chk("access rsp", rsp(), 2'b00);
      @(negedge clk);
      #1;
    end
    chk("resp pulse", rsp(), onehot);
    chk("resp rdata", bus.rsp_rdata, v.expRdata);
    chk("resp mem_en", mem_en, 1'b0);
    chk("resp busy", busy, 1'b1);
    @(negedge clk);
    #1;
    chk("post rsp", rsp(), 2'b00);
    chk("post busy", busy, 1'b0);
    chk("post owner", owner, 1'b0);
  endtask

  initial begin
    logic [1:0] expGrant[4];
    logic [1:0] seen;
    logic [1:0] r;
    int         waitCyc;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,           32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678,   32'hAAAA_5555, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,           32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D,   32'h1111_1111, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,           32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,           32'hFFFF_FFFF, 32'hFFFF_FFFF};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    rst_n = 1'b0;
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    memRdata = '0;
    busZ.req0_valid = 1'b0; busZ.req1_valid = 1'b0;
    busZ.req0_write = 1'b0; busZ.req1_write = 1'b0;
    busZ.req0_addr  = '0;   busZ.req1_addr  = '0;
    busZ.req0_wdata = '0;   busZ.req1_wdata = '0;
    memRdataZ = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset mem_en", mem_en, 1'b0);
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset rsp", rsp(), 2'b00);
    chk("reset rdata", bus.rsp_rdata, 32'h0);
    chk("reset owner", owner, 1'b0);
    chk("reset ready", rdy(), 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-port transactions
    for (int k = 0; k < 6; k++) runTxn(vecs[k]);

    // Both ports held valid: grant sequence depends on policy
    @(negedge clk);
    drive(2'b11, 1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      waitCyc = 0;
      #1 r = rdy();
      while (r == 2'b00 && waitCyc < 10) begin
        @(negedge clk);
        #1 r = rdy();
        waitCyc++;
      end
      chk("contention grant", r, expGrant[k]);
      @(negedge clk);
    end
    drive(2'b10, 1'b0, 32'h44, 32'h0);
    waitCyc = 0;
    #1 r = rdy();
    while (r == 2'b00 && waitCyc < 10) begin
      @(negedge clk);
      #1 r = rdy();
      waitCyc++;
    end
    chk("port1 after port0 drops", r, 2'b10);
    @(negedge clk);
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    #1 chk("contention idle busy", busy, 1'b0);

    // Port 1 raises valid while port 0 is being served
    @(negedge clk);
    drive(2'b01, 1'b0, 32'h50, 32'h0);
    #1 chk("late first ready", rdy(), 2'b01);
    @(negedge clk);
    drive(2'b10, 1'b0, 32'h54, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      #1 chk("late held off", rdy(), 2'b00);
      @(negedge clk);
    end
    #1 chk("late served T+5", rdy(), 2'b10);
    @(negedge clk);
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);

    // Reset in second ACCESS cycle of a write
    drive(2'b10, 1'b1, 32'h60, 32'h7777_0000);
    #1 chk("rst-test accept", rdy(), 2'b10);
    @(negedge clk);
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("rst-test mem_we pre", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst-test mem_en", mem_en, 1'b0);
    chk("rst-test mem_we", mem_we, 1'b0);
    chk("rst-test busy", busy, 1'b0);
    chk("rst-test rsp", rsp(), 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1 seen = seen | rsp();
      @(negedge clk);
    end
    chk("rst-test no completion", seen, 2'b00);
    runTxn(vecs[0]);

    // WAIT_CYCLES = 0 instance
    @(negedge clk);
    busZ.req0_valid = 1'b1;
    busZ.req0_addr  = 32'h70;
    memRdataZ       = 32'h5A5A_1234;
    #1 chk("w0 ready", busZ.req0_ready, 1'b1);
    @(negedge clk);
    busZ.req0_valid = 1'b0;
    #1;
    chk("w0 mem_en T+1", memEnZ, 1'b1);
    chk("w0 mem_addr", memAddrZ, 32'h70);
    @(negedge clk);
    #1;
    chk("w0 mem_en T+2", memEnZ, 1'b0);
    chk("w0 rsp T+2", {busZ.rsp1_valid, busZ.rsp0_valid}, 2'b01);
    chk("w0 rdata", busZ.rsp_rdata, 32'h5A5A_1234);
    @(negedge clk);
    #1;
    chk("w0 idle", busyZ, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single unified memory of the multicycle datapath and shares it between two requesters: port 0 (CPU fetch/load/store path driven by the control FSM) and port 1 (program loader / debug port). Accepts one request at a time with a valid/ready handshake, holds the memory access for a fixed number of wait cycles, then returns a one-cycle completion pulse with read data to the owning port. Sits between the CPU control/datapath and the memory block; the CPU control FSM treats a deasserted `req0_ready` or an absent `rsp0_valid` as a stall.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 2, memory access cycles minus one; legal range 0..15

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `reqN_valid`  in  1  request from port N (N = 0, 1)
- `reqN_write`  in  1  1 = write, 0 = read
- `reqN_addr`  in  ADDR_W  access address
- `reqN_wdata`  in  DATA_W  write data
- `reqN_ready`  out  1  request accepted this cycle (combinational)
- `rspN_valid`  out  1  one-cycle completion pulse to port N
- `rsp_rdata`  out  DATA_W  read data, valid with `rspN_valid` of a read
- `mem_en`  out  1  memory access enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in any state other than IDLE
- `owner`  out  1  port currently owning the access

## Operation
- States: IDLE, ACCESS, RESP. Reset: IDLE; all outputs 0; `last_owner` = 1; counter 0; latched addr/wdata/write 0.
- IDLE: if any `reqN_valid`, select winner; assert `reqN_ready` to the winner only; latch addr, wdata, write, owner; load counter = `WAIT_CYCLES`; go ACCESS. No valid: stay IDLE.
- Handshake: transfer occurs when `reqN_valid && reqN_ready`. `reqN_ready` is 0 in every state except IDLE. The losing port keeps its request asserted and is served later; a requester must not drop valid before ready.
- ACCESS: `mem_en` = 1, `mem_we` = latched write, `mem_addr`/`mem_wdata` from latches, stable for whole state. Counter decrements each cycle; when counter == 0, capture `mem_rdata` into `rsp_rdata` register and go RESP.
- RESP: pulse `rsp{owner}_valid` for exactly one cycle; `rsp_rdata` holds captured value until next capture (writes leave it unchanged); update `last_owner` = owner; go IDLE.
- Selection: both valid, arbitration per Configuration; single valid, that port wins.
- `owner` reflects latched owner in ACCESS/RESP, 0 in IDLE.
- `WAIT_CYCLES` arithmetic: counter is 4 bits, never underflows (reload only in IDLE).

## Timing
- Acceptance in cycle T (IDLE); `mem_en` high T+1 .. T+1+`WAIT_CYCLES`; `rspN_valid` at T+2+`WAIT_CYCLES`; earliest next acceptance T+3+`WAIT_CYCLES`.
- WAIT_CYCLES = 2: accept T, response T+4, next accept T+5.
- Simultaneous request in IDLE and response in RESP cannot occur (RESP never accepts).
- Reset asserted mid-ACCESS or mid-RESP: immediately IDLE, `mem_en`/`mem_we`/`rspN_valid` drop asynchronously; no completion pulse for the aborted access.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on contention, winner = port not equal to `last_owner` (alternation; port 0 wins first contention after reset).
- Not defined: fixed priority, port 0 always wins contention; `last_owner` still maintained but unused.

## Structure
- Shared package: state enum (IDLE, ACCESS, RESP), port index constants `PORT_CPU` = 0 and `PORT_LDR` = 1, `WAIT_W` = 4.
- One sub-module: `mem_arb_select` (combinational winner pick from valids, `last_owner`, macro-dependent policy). FSM, counter and latches stay in top.

## Test plan
- Port 0 read addr 0x10, memory returns 0xDEADBEEF, WAIT_CYCLES=2 -> `req0_ready` at T, `mem_en` T+1..T+3, `rsp0_valid` at T+4 with `rsp_rdata` 0xDEADBEEF.
- Port 1 write addr 0x20 data 0x12345678 -> `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x12345678 for 3 cycles; `rsp1_valid` one pulse; `rsp0_valid` never.
- Both ports hold valid for 4 transactions -> with macro grants 0,1,0,1; without macro 0,0,0,0 and port 1 starved until port 0 drops.
- Request asserted during ACCESS by other port -> `req*_ready` stays 0 until IDLE; served at T+5.
- `rst_n` low in second ACCESS cycle -> `mem_en` 0 immediately, no `rspN_valid`, `busy` 0, next request accepted normally.
- WAIT_CYCLES=0 -> `mem_en` single cycle T+1, response at T+2.
